// File: rtl/csr_spmv_run_ctrl.sv
// Run sequencer for the HLS CSR SpMV core: resets the core, starts it a requested number of
// times per batch, captures y-port writes for readback, times the batch and aborts a hung core.
module csr_spmv_run_ctrl #(
    parameter int AW      = 3,
    parameter int DW      = 32,
    parameter int RST_CYC = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    input  logic          cmd_start,
    input  logic [7:0]    cmd_runs,
    output logic          busy,
    output logic          done,
    output logic          timeout_err,
    output logic [7:0]    runs_done,
    output logic [31:0]   cycle_count,
    output logic          core_ap_rst,
    output logic          core_ap_start,
    input  logic          core_ap_done,
    input  logic          core_ap_ready,
    input  logic          core_ap_idle,
    input  logic          y_ce0,
    input  logic          y_we0,
    input  logic [AW-1:0] y_address0,
    input  logic [DW-1:0] y_d0,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int DEPTH = 1 << AW;
    localparam int CMAX  = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
    localparam int CW    = $clog2(CMAX + 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CRST, S_START, S_WAIT, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;            // CRST length, then per-run watchdog
    logic [7:0]    runs_q, runs_d;
    logic [7:0]    runs_done_q, runs_done_d;
    logic          timeout_err_q, timeout_err_d;
    logic [31:0]   cycle_count_q, cycle_count_d;
    logic          clear_buf;
    logic [DW-1:0] buf_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    // Idle status is informational only; sequencing relies on ready/done.
    logic unused_idle;
    assign unused_idle = core_ap_idle;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        runs_d        = runs_q;
        runs_done_d   = runs_done_q;
        timeout_err_d = timeout_err_q;
        clear_buf     = 1'b0;
        cycle_count_d = cycle_count_q;
        if (state_q != S_IDLE && cycle_count_q != '1) cycle_count_d = cycle_count_q + 32'd1;

        unique case (state_q)
            S_IDLE: if (cmd_start) begin
                runs_d        = cmd_runs;
                runs_done_d   = '0;
                timeout_err_d = 1'b0;
                cycle_count_d = '0;
                clear_buf     = 1'b1;
                cnt_d         = '0;
                state_d       = (cmd_runs == 8'd0) ? S_DONE : S_CRST;
            end
            S_CRST: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d = cnt_q + 1'b1;
                if (core_ap_ready) begin
                    if (core_ap_done) begin
                        runs_done_d = runs_done_q + 8'd1;
                        state_d     = S_NEXT;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_ERR;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (core_ap_done) begin
                    runs_done_d = runs_done_q + 8'd1;
                    state_d     = S_NEXT;
                end else if (cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_ERR;
                end
            end
            S_NEXT: begin
                if (runs_done_q == runs_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            runs_q        <= '0;
            runs_done_q   <= '0;
            timeout_err_q <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            runs_q        <= runs_d;
            runs_done_q   <= runs_done_d;
            timeout_err_q <= timeout_err_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // NOTE: the result buffer is reset and bulk-cleared on purpose: readback must show zeros
    // for entries the current batch never wrote, so it stays in flops rather than a RAM.
    always_ff @(posedge ap_clk) begin
        if (ap_rst || clear_buf) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        end else if (y_ce0 && y_we0 && (state_q == S_START || state_q == S_WAIT)) begin
            buf_q[y_address0] <= y_d0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) rd_data_q <= '0;
        else        rd_data_q <= buf_q[rd_addr];
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign timeout_err   = timeout_err_q;
    assign runs_done     = runs_done_q;
    assign cycle_count   = cycle_count_q;
    assign core_ap_start = (state_q == S_START);
    assign core_ap_rst   = ap_rst || (state_q == S_CRST) || (state_q == S_ERR);
    assign rd_data       = rd_data_q;

endmodule
